mc8051_mem_resp: RTL

- Memory-side responder for the mc8051 core; the far end of the core's stage-selected address/write-data path.
- Accepts one byte-wide memory request at a time and routes it to internal IRAM, the SFR strobe port, or the external CODE/XRAM bus.
- Returns completion and read data for capture into the core's stage data buffers.
- Owns bus wait-state handling, timeout and access-error reporting.

---
 rtl/mc8051_mem_resp.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc8051_mem_resp.sv
// Memory-side responder for the mc8051 core: routes one byte request at a time to IRAM, SFR strobes or the external bus.
// Define MC8051_MEM_WPOST_EN to post XRAM writes into a one-entry buffer that completes on the bus in the background.
module mc8051_mem_resp #(
    parameter int unsigned IRAM_AW     = 8,
    parameter int unsigned BUS_TIMEOUT = 16,
    parameter logic [7:0]  TMO_RDATA   = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_req,
    output logic        o_mem_ready,
    input  logic        i_mem_we,
    input  logic [1:0]  i_mem_space,
    input  logic [15:0] i_mem_addr,
    input  logic [7:0]  i_mem_wdata,
    output logic        o_mem_done,
    output logic [7:0]  o_mem_rdata,
    output logic        o_mem_err,
    output logic        o_sfr_re,
    output logic        o_sfr_we,
    output logic [7:0]  o_sfr_addr,
    output logic [7:0]  o_sfr_wdata,
    input  logic [7:0]  i_sfr_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic        o_bus_code,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [7:0]  i_bus_rdata
);

    localparam logic [1:0] SP_CODE = 2'd0;
    localparam logic [1:0] SP_IRAM = 2'd1;
    localparam logic [1:0] SP_XRAM = 2'd2;
    localparam logic [1:0] SP_SFR  = 2'd3;

    localparam int unsigned      CNT_W    = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);
    localparam bit               TMO_EN   = (BUS_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOC  = 2'd1,
        ST_BUS  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic             we_q;
    logic [1:0]       space_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       rdata_q;
    logic             sfr_re_q;
    logic             sfr_we_q;
    logic [7:0]       sfr_addr_q;
    logic [7:0]       sfr_wdata_q;
    logic             bus_req_q;
    logic             bus_we_q;
    logic             bus_code_q;
    logic [15:0]      bus_addr_q;
    logic [7:0]       bus_wdata_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [7:0]       iram_rd_q;
    logic [7:0]       iram_mem [2**IRAM_AW];

    logic ready;
    logic accept;
    logic req_local;
    logic req_code_wr;
    logic req_post;
    logic bus_active;
    logic bus_tmo;
    logic bus_end;

    assign req_local   = (i_mem_space == SP_IRAM) || (i_mem_space == SP_SFR);
    assign req_code_wr = i_mem_we && (i_mem_space == SP_CODE);
    assign accept      = i_mem_req && ready;

`ifdef MC8051_MEM_WPOST_EN
    logic pw_valid_q;
    assign req_post   = i_mem_we && (i_mem_space == SP_XRAM);
    assign bus_active = (state_q == ST_BUS) || pw_valid_q;
`else
    assign req_post   = 1'b0;
    assign bus_active = (state_q == ST_BUS);
`endif

    // An ack on the final permitted cycle wins over the timeout.
    assign bus_tmo = TMO_EN && bus_active && !i_bus_ack && (tmo_cnt_q == CNT_LAST);
    assign bus_end = bus_active && (i_bus_ack || bus_tmo);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_local) begin
                        state_d = ST_LOC;
                    end else if (req_code_wr) begin
                        state_d = ST_DONE;
                    end else if (req_post) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_LOC:  state_d = ST_DONE;
            ST_BUS:  if (bus_end) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
`ifdef MC8051_MEM_WPOST_EN
        // Bus-bound requests wait behind a posted write to keep ordering.
        if (pw_valid_q && !req_local) ready = 1'b0;
`endif
    end

    assign o_mem_ready = ready;
    assign o_mem_done  = done_q;
    assign o_mem_err   = err_q;
    assign o_mem_rdata = rdata_q;
    assign o_sfr_re    = sfr_re_q;
    assign o_sfr_we    = sfr_we_q;
    assign o_sfr_addr  = sfr_addr_q;
    assign o_sfr_wdata = sfr_wdata_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_code  = bus_code_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;

    // IRAM is accessed on the accept edge so the read byte is ready by the end of LOC.
    always_ff @(posedge i_clk) begin
        if (accept && (i_mem_space == SP_IRAM)) begin
            if (i_mem_we) begin
                iram_mem[i_mem_addr[IRAM_AW-1:0]] <= i_mem_wdata;
            end
            iram_rd_q <= iram_mem[i_mem_addr[IRAM_AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q        <= 1'b0;
            space_q     <= SP_CODE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            sfr_re_q    <= 1'b0;
            sfr_we_q    <= 1'b0;
            sfr_addr_q  <= '0;
            sfr_wdata_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_code_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            tmo_cnt_q   <= '0;
`ifdef MC8051_MEM_WPOST_EN
            pw_valid_q  <= 1'b0;
`endif
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sfr_re_q <= 1'b0;
            sfr_we_q <= 1'b0;

            if (accept) begin
                we_q    <= i_mem_we;
                space_q <= i_mem_space;
                if (i_mem_space == SP_SFR) begin
                    sfr_re_q    <= !i_mem_we;
                    sfr_we_q    <= i_mem_we;
                    sfr_addr_q  <= i_mem_addr[7:0];
                    sfr_wdata_q <= i_mem_wdata;
                end
                if (req_code_wr) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else if (!req_local) begin
                    bus_req_q   <= 1'b1;
                    bus_we_q    <= i_mem_we;
                    bus_code_q  <= (i_mem_space == SP_CODE);
                    bus_addr_q  <= i_mem_addr;
                    bus_wdata_q <= i_mem_wdata;
                end
`ifdef MC8051_MEM_WPOST_EN
                if (req_post) begin
                    done_q     <= 1'b1;
                    pw_valid_q <= 1'b1;
                end
`endif
            end

            if (state_q == ST_LOC) begin
                done_q <= 1'b1;
                if (!we_q) begin
                    rdata_q <= (space_q == SP_SFR) ? i_sfr_rdata : iram_rd_q;
                end
            end

            if (bus_end) begin
                bus_req_q <= 1'b0;
                tmo_cnt_q <= '0;
`ifdef MC8051_MEM_WPOST_EN
                if (pw_valid_q) begin
                    pw_valid_q <= 1'b0;
                    err_q      <= bus_tmo;
                end else begin
                    done_q <= 1'b1;
                    err_q  <= bus_tmo;
                    if (!we_q) rdata_q <= bus_tmo ? TMO_RDATA : i_bus_rdata;
                end
`else
                done_q <= 1'b1;
                err_q  <= bus_tmo;
                if (!we_q) rdata_q <= bus_tmo ? TMO_RDATA : i_bus_rdata;
`endif
            end else if (bus_active) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
